// File: rtl/pause_dim_ctrl.sv
// Pause and screen-dim controller: merges user/external pause and fades RGB after idle.
// Define PAUSE_VBLANK_ALIGN_EN to commit user pause entry/exit only on a vblank rising edge.
module pause_dim_ctrl #(
  parameter int unsigned CW          = 8,
  parameter int unsigned NCH         = 3,
  parameter int unsigned NSRC        = 1,
  parameter int unsigned DIM_CYCLES  = 110000000,
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned MAX_DIM     = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         btn_pause,
  input  logic [NSRC-1:0]              pause_req,
  input  logic                         vblank,
  input  logic [NCH*CW-1:0]            rgb_in,
  output logic [NCH*CW-1:0]            rgb_out,
  output logic                         pause,
  output logic                         user_paused,
  output logic [$clog2(MAX_DIM+1)-1:0] dim_level
);

  localparam int unsigned DW  = NCH * CW;
  localparam int unsigned DLW = $clog2(MAX_DIM + 1);
  localparam int unsigned TW  = 32;

  localparam logic [TW-1:0]  DIM_LAST  = TW'(DIM_CYCLES - 1);
  localparam logic [TW-1:0]  STEP_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [DLW-1:0] DIM_MAX   = DLW'(MAX_DIM);

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_WAIT       = 3'd1,
    S_DIM        = 3'd2
`ifdef PAUSE_VBLANK_ALIGN_EN
    ,
    S_ARM_PAUSE  = 3'd3,
    S_ARM_RESUME = 3'd4
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   step_q, step_d;
  logic [DLW-1:0]  dim_q, dim_d;
  logic            btn_q, btn_d;
  logic            user_paused_q, user_paused_d;
  logic [DW-1:0]   rgb_out_q, rgb_out_d;

  logic            btn_rise_c;
  logic [TW-1:0]   timer_adv_c;
  logic [TW-1:0]   step_adv_c;
  logic [DLW-1:0]  dim_adv_c;
  state_t          paused_state_c;

`ifdef PAUSE_VBLANK_ALIGN_EN
  logic            vblank_q, vblank_d;
  logic            vb_rise_c;
`else
  logic            unused_vblank;
  assign unused_vblank = vblank;
`endif

  // Edge detection against the 1-cycle delayed copies
  always_comb begin
    btn_d      = btn_pause;
    btn_rise_c = btn_pause & ~btn_q;
`ifdef PAUSE_VBLANK_ALIGN_EN
    vblank_d   = vblank;
    vb_rise_c  = vblank & ~vblank_q;
`endif
  end

  // One cycle of idle-timer / fade progression while user pause is in effect
  always_comb begin
    timer_adv_c = timer_q;
    step_adv_c  = step_q;
    dim_adv_c   = dim_q;
    if (dim_q == '0) begin
      if (timer_q == DIM_LAST) begin
        dim_adv_c  = DLW'(1);
        step_adv_c = '0;
      end else begin
        timer_adv_c = timer_q + TW'(1);
      end
    end else if (dim_q != DIM_MAX) begin
      if (step_q == STEP_LAST) begin
        dim_adv_c  = dim_q + DLW'(1);
        step_adv_c = '0;
      end else begin
        step_adv_c = step_q + TW'(1);
      end
    end
    paused_state_c = (dim_adv_c != '0) ? S_DIM : S_WAIT;
  end

  // Next-state logic; any return to RUN clears the fade registers in the same cycle
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = step_q;
    dim_d   = dim_q;
    case (state_q)
      S_RUN: begin
        if (btn_rise_c) begin
`ifdef PAUSE_VBLANK_ALIGN_EN
          state_d = S_ARM_PAUSE;
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_WAIT, S_DIM: begin
        timer_d = timer_adv_c;
        step_d  = step_adv_c;
        dim_d   = dim_adv_c;
        state_d = paused_state_c;
        if (btn_rise_c) begin
`ifdef PAUSE_VBLANK_ALIGN_EN
          state_d = S_ARM_RESUME;
`else
          state_d = S_RUN;
          timer_d = '0;
          step_d  = '0;
          dim_d   = '0;
`endif
        end
      end
`ifdef PAUSE_VBLANK_ALIGN_EN
      S_ARM_PAUSE: begin
        if (btn_rise_c) begin
          state_d = S_RUN;
        end else if (vb_rise_c) begin
          state_d = S_WAIT;
        end
      end
      S_ARM_RESUME: begin
        timer_d = timer_adv_c;
        step_d  = step_adv_c;
        dim_d   = dim_adv_c;
        if (btn_rise_c) begin
          state_d = paused_state_c;
        end else if (vb_rise_c) begin
          state_d = S_RUN;
          timer_d = '0;
          step_d  = '0;
          dim_d   = '0;
        end
      end
`endif
      default: begin
        state_d = S_RUN;
        timer_d = '0;
        step_d  = '0;
        dim_d   = '0;
      end
    endcase
  end

  // Registered outputs: pause flag from next state, pixel shifted by current level
  always_comb begin
    user_paused_d = (state_d == S_WAIT) || (state_d == S_DIM)
`ifdef PAUSE_VBLANK_ALIGN_EN
                    || (state_d == S_ARM_RESUME)
`endif
                    ;
    rgb_out_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      rgb_out_d[c*CW +: CW] = rgb_in[c*CW +: CW] >> dim_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      timer_q       <= '0;
      step_q        <= '0;
      dim_q         <= '0;
      btn_q         <= 1'b0;
      user_paused_q <= 1'b0;
      rgb_out_q     <= '0;
`ifdef PAUSE_VBLANK_ALIGN_EN
      vblank_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      step_q        <= step_d;
      dim_q         <= dim_d;
      btn_q         <= btn_d;
      user_paused_q <= user_paused_d;
      rgb_out_q     <= rgb_out_d;
`ifdef PAUSE_VBLANK_ALIGN_EN
      vblank_q      <= vblank_d;
`endif
    end
  end

  assign rgb_out     = rgb_out_q;
  assign user_paused = user_paused_q;
  assign dim_level   = dim_q;
  assign pause       = user_paused_q | (|pause_req);

endmodule

// File: doc/pause_dim_ctrl.md
# pause_dim_ctrl

Parametrised pause and screen-dim controller placed between the arcade core's video output and `arcade_video`. It merges a user pause button and any number of external pause requests (hiscore, OSD) into one `pause` output. After a configurable idle time under user pause, it fades the RGB stream down in configurable shift steps. It is the generalised form of the per-core inline pause logic: any colour width or channel count, multi-step fade, and optional frame-aligned pause entry and exit.

## Interface
Parameters:
- `CW`, 8: bits per colour channel (1..8).
- `NCH`, 3: number of colour channels.
- `NSRC`, 1: number of external pause request inputs (≥1).
- `DIM_CYCLES`, 110000000: clock cycles of user pause before the first dim step (1..2^32-1).
- `STEP_CYCLES`, 1: clock cycles between successive dim steps (≥1).
- `MAX_DIM`, 1: maximum right-shift applied per channel (1..CW).

Ports:
- `clk`, in, 1: system clock. One clock domain only.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `btn_pause`, in, 1: user pause button, level, synchronous to `clk`.
- `pause_req`, in, NSRC: external pause requests, level, active-high.
- `vblank`, in, 1: vertical blank from the core, synchronous to `clk`.
- `rgb_in`, in, NCH*CW: packed pixel, channel 0 in the LSBs.
- `rgb_out`, out, NCH*CW: registered, dimmed pixel.
- `pause`, out, 1: `user_paused | (|pause_req)`, combinational.
- `user_paused`, out, 1: user pause is in effect.
- `dim_level`, out, $clog2(MAX_DIM+1): current shift amount.

## Operation
- The rising edge of `btn_pause` is detected from a 1-cycle delayed copy. That delay register resets to 0, so a button held high through reset release produces one edge.
- States are RUN, ARM_PAUSE, WAIT, DIM, ARM_RESUME.
  - RUN: on an edge, go to WAIT. With `PAUSE_VBLANK_ALIGN_EN`, go to ARM_PAUSE instead.
  - ARM_PAUSE: on a `vblank` rising edge, go to WAIT. On another button edge, return to RUN (cancel).
  - WAIT: `user_paused`=1. The 32-bit timer counts up from 0. When timer == DIM_CYCLES-1, go to DIM with `dim_level`=1 and the step counter at 0. On an edge, go to RUN, or to ARM_RESUME if aligned.
  - DIM: the step counter counts to STEP_CYCLES-1, then `dim_level` increments and the counter clears. `dim_level` saturates at MAX_DIM and the state holds. An edge exits as from WAIT.
  - ARM_RESUME: `user_paused`=1, and timer and dim keep evolving. A `vblank` rising edge goes to RUN. A button edge cancels back to the state that armed it.
- Entering RUN clears the timer, the step counter and `dim_level` in the same cycle.
- In WAIT, DIM and ARM_RESUME, `user_paused`=1; in RUN and ARM_PAUSE it is 0.
- `pause_req` never arms, holds or affects the dim timer. It only ORs into `pause`.
- Per channel: `rgb_out[c] = rgb_in[c] >> dim_level`, zero-filled at the MSBs, registered.
- A `vblank` rising edge in the same cycle as a button edge: the button edge is acted on first. The vblank edge does not commit a transition arming in that same cycle; the commit needs a later vblank rise.

## Timing
- Reset (async assert): state RUN; `rgb_out`=0, `user_paused`=0, `dim_level`=0; timer, step counter and edge/vblank delay registers all 0. `pause` then equals `|pause_req`.
- Reset asserted mid-dim clears immediately, with no fade-back.
- `rgb_out` latency is 1 cycle from `rgb_in`, using the `dim_level` registered in the previous cycle.
- Unaligned pause: `user_paused` rises 1 cycle after the `btn_pause` rising edge is sampled.
- First dim step: `dim_level` becomes 1 exactly DIM_CYCLES cycles after `user_paused` rises. Each further step follows STEP_CYCLES cycles later.
- `pause` has zero added latency with respect to `pause_req` and `user_paused`.

## Configuration
- `PAUSE_VBLANK_ALIGN_EN` defined: the ARM_PAUSE and ARM_RESUME states exist. User pause entry and exit commit only on a `vblank` rising edge, so the frame is never frozen mid-scan.
- Not defined: these states are removed, transitions are immediate as described above, and the `vblank` input is ignored.

## Test plan
- Parameters CW=8, NCH=3, DIM_CYCLES=16, STEP_CYCLES=4, MAX_DIM=2, unaligned; `rgb_in`=0xFF80FF, press `btn_pause` → `user_paused`=1 next cycle; after 16 cycles `dim_level`=1 and `rgb_out`=0x7F407F; after 4 more cycles `dim_level`=2 and `rgb_out`=0x3F203F, holding there.
- While `dim_level`=2, press the button again → next cycle `user_paused`=0 and `dim_level`=0; one cycle later `rgb_out`=`rgb_in`.
- `pause_req`=1 for 100 cycles with no button → `pause`=1 throughout, `dim_level` stays 0, `rgb_out`=`rgb_in` delayed 1 cycle.
- Aligned build: press the button with `vblank`=0 → `user_paused` stays 0; a `vblank` rise 50 cycles later gives `user_paused`=1 the next cycle. A second press before that vblank cancels, and `user_paused` never rises.
- Drop `reset_n` low during DIM → `rgb_out`=0, `dim_level`=0 and `user_paused`=0 immediately (asynchronously). After release, state is RUN.
- Button edge and `vblank` rise in the same cycle in RUN (aligned build) → ARM_PAUSE; commit happens only on the next vblank rise.
